// File: rtl/fetch_stall_if.sv
// Fetch/stall interface: hazard-unit requests and instruction-memory data into
// the fetch stage, PC, IF/ID register contents and stall statistics out of it.
//   pc_stall_i, stall_hold_i     : hold PC / hold IF/ID requests
//   branch_taken_i, branch_target_i : redirect request and address
//   instr_i                      : instruction memory data for pc_o
//   pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o : fetch state
//   stall_cnt_o, stall_run_o, stall_err_o          : stall statistics
interface fetch_stall_if;
  logic        pc_stall_i;
  logic        stall_hold_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic [15:0] stall_cnt_o;
  logic [7:0]  stall_run_o;
  logic        stall_err_o;

  // Requester side: hazard unit, branch resolution and instruction memory.
  modport master (
    output pc_stall_i, stall_hold_i, branch_taken_i, branch_target_i, instr_i,
    input  pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
    input  stall_cnt_o, stall_run_o, stall_err_o
  );

  // Fetch-stage side.
  modport slave (
    input  pc_stall_i, stall_hold_i, branch_taken_i, branch_target_i, instr_i,
    output pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
    output stall_cnt_o, stall_run_o, stall_err_o
  );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// Fetch stall controller: owns the PC and IF/ID register, applies stall, hold
// and branch-redirect requests, and tracks stall statistics with a sticky
// error when a stall run reaches STALL_MAX cycles.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : fetch_stall_if.slave (requests in, fetch state and statistics out)
module fetch_stall_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [7:0]  STALL_MAX = 8'd16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_stall_if.slave bus
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned RUN_W = 8;

  logic [PC_W-1:0]  r_pc, r_if_pc, r_if_instr;
  logic             r_if_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [RUN_W-1:0] r_run;
  logic             r_err;

  logic [PC_W-1:0]  w_pc_nxt, w_if_pc_nxt, w_if_instr_nxt, w_pc_plus4;
  logic             w_if_valid_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_err_nxt;
  logic             w_stall;

  // A hold of IF/ID always implies a hold of the PC.
  assign w_stall    = bus.pc_stall_i | bus.stall_hold_i;
  assign w_pc_plus4 = PC_W'(r_pc + PC_W'(4));

  // Datapath next state; stalls take priority over a branch, which is
  // re-asserted by ID once its operands are ready.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_if_valid_nxt = r_if_valid;
    if (bus.stall_hold_i) begin
      w_pc_nxt = r_pc;
    end else if (bus.pc_stall_i) begin
      w_if_instr_nxt = '0;
      w_if_valid_nxt = 1'b0;
    end else if (bus.branch_taken_i) begin
      w_pc_nxt       = bus.branch_target_i;
      w_if_instr_nxt = '0;
      w_if_valid_nxt = 1'b0;
    end else begin
      w_pc_nxt       = w_pc_plus4;
      w_if_pc_nxt    = w_pc_plus4;
      w_if_instr_nxt = bus.instr_i;
      w_if_valid_nxt = 1'b1;
    end
  end

  // Saturating stall statistics and sticky run-length error.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_run_nxt = '0;
    w_err_nxt = r_err;
    if (w_stall) begin
      if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
      if (r_run != {RUN_W{1'b1}}) w_run_nxt = RUN_W'(r_run + RUN_W'(1));
      else                        w_run_nxt = r_run;
    end
    if (w_run_nxt >= STALL_MAX) w_err_nxt = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc       <= PC_RESET;
      r_if_pc    <= '0;
      r_if_instr <= '0;
      r_if_valid <= 1'b0;
      r_cnt      <= '0;
      r_run      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_cnt      <= w_cnt_nxt;
      r_run      <= w_run_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign bus.pc_o          = r_pc;
  assign bus.if_id_pc_o    = r_if_pc;
  assign bus.if_id_instr_o = r_if_instr;
  assign bus.if_id_valid_o = r_if_valid;
  assign bus.stall_cnt_o   = r_cnt;
  assign bus.stall_run_o   = r_run;
  assign bus.stall_err_o   = r_err;

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
- Receiving end of the hazard-detection stall interface.
- Owns the PC register and the IF/ID pipeline register, and applies the stall, hold and branch-redirect requests to them.
- Sits between instruction memory and the ID stage.
- Keeps stall statistics and raises a sticky error when a stall runs too long, to catch a hazard unit stuck asserted.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded at reset.
- STALL_MAX, 8'd16, number of consecutive stall cycles at which stall_err_o sets.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- pc_stall_i  input  1  from hazard unit: hold the PC.
- stall_hold_i  input  1  from hazard unit: hold the IF/ID register.
- branch_taken_i  input  1  branch resolved taken in ID: redirect fetch and squash IF/ID.
- branch_target_i  input  32  redirect address, used when branch_taken_i is accepted.
- instr_i  input  32  instruction memory data for address pc_o (combinational memory).
- pc_o  output  32  current fetch address.
- if_id_pc_o  output  32  registered PC+4 of the instruction in IF/ID.
- if_id_instr_o  output  32  registered instruction; 32'h0 (NOP) when a bubble.
- if_id_valid_o  output  1  IF/ID holds a real instruction.
- stall_cnt_o  output  16  total stall cycles since reset, saturating.
- stall_run_o  output  8  current consecutive stall cycles, saturating.
- stall_err_o  output  1  sticky; set once stall_run reaches STALL_MAX.

Behaviour:
- Reset (rst_i=0, takes effect immediately, no clock needed):
  - pc_o=PC_RESET, if_id_pc_o=0, if_id_instr_o=0, if_id_valid_o=0.
  - stall_cnt_o=0, stall_run_o=0, stall_err_o=0.
  - Reset mid-stall or mid-branch discards everything, including the sticky error.
- Definitions: pc_hold = pc_stall_i | stall_hold_i (hold implies PC hold); stall = pc_hold.
- Each rising edge, in priority order:
  1. stall_hold_i=1:
     - PC holds; IF/ID holds (pc, instr, valid unchanged).
     - branch_taken_i is ignored: a stalled branch's operands are not ready, and ID reasserts the branch after the stall.
  2. pc_stall_i=1, stall_hold_i=0:
     - PC holds; IF/ID loads bubble (instr=0, valid=0, if_id_pc unchanged).
     - branch_taken_i is ignored.
  3. branch_taken_i=1, no stall:
     - pc <= branch_target_i; IF/ID loads bubble (instr=0, valid=0).
  4. Otherwise:
     - pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
     - if_id_pc <= pc+4, if_id_instr <= instr_i, valid <= 1.
- Latency:
  - instr_i for address pc_o appears on if_id_instr_o one cycle later.
  - A redirect appears on pc_o one cycle after the branch_taken edge.
- branch_target_i is not checked for alignment; the low 2 bits pass through unchanged.
- Counters, updated on the same edge:
  - stall_cnt: +1 when stall=1; saturates at 16'hFFFF and never wraps.
  - stall_run: +1 when stall=1, saturating at 8'hFF; cleared to 0 on any edge with stall=0.
  - stall_err: set on the edge where the stall_run next value >= STALL_MAX.
    - Stays set until reset; it has no effect on datapath behaviour.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset release, no stalls, instr_i=address-tagged pattern, 4 cycles:
  - pc_o = 0, 4, 8, 12.
  - if_id_instr_o lags one cycle; if_id_pc_o = 4, 8, 12; valid=1 from cycle 1.
  - Counters stay 0.
- Load-use stall (pc_stall_i=stall_hold_i=1) for 1 cycle at pc=8:
  - pc_o holds 8 for 2 cycles; IF/ID holds the instruction fetched at 4.
  - stall_cnt_o=1; stall_run_o=1, then 0 on the next cycle.
- pc_stall_i=1, stall_hold_i=0 at pc=0x20:
  - pc holds 0x20; if_id_instr_o=0, valid=0 next cycle.
  - Next normal cycle loads the instruction at 0x20 with if_id_pc_o=0x24.
- branch_taken_i=1, target 0x100, together with stall_hold_i=1:
  - Branch ignored; pc holds.
  - Next cycle branch_taken_i=1 with no stall: pc_o=0x100, IF/ID bubble.
  - Following cycle if_id_pc_o=0x104.
- Continuous stall for 20 cycles:
  - stall_err_o rises on the 16th stall edge and stall_run_o=16 there.
  - After the stall drops, stall_run_o=0 and stall_err_o stays 1.
  - rst_i pulsed low mid-clock: all outputs return to reset values immediately.
- pc starting at 0xFFFF_FFF8, no stalls:
  - pc_o = FFFF_FFF8, FFFF_FFFC, 0000_0000; if_id_pc_o wraps to 0 likewise.
